// File: rtl/l2_width_conv_buffer.sv
// rtl/l2_width_conv_buffer.sv - narrow/wide ring buffer between L1 and DDR sides
//
// Ring buffer with a narrow (NW) L1 port and a wide (NW*RATIO) DDR port.
// Fill mode moves DDR -> L1; flush mode moves L1 -> DDR, with drain of a
// lane-masked partial wide word. Storage is RATIO narrow-lane banks.
//
// Ports:
//   clk_166M66, mcu_sys_rst_n     clock, synchronous active-low reset
//   i_clear                       synchronous flush of contents and error flags
//   i_mode, i_mode_load, o_mode   mode request/strobe/active (0 fill, 1 flush)
//   o_mode_err                    one-cycle pulse on a rejected mode load
//   i_l1_w*, o_l1_wready          L1 push (flush mode)
//   o_l1_r*, i_l1_rready          L1 pop (fill mode)
//   i_ddr_w*, o_ddr_wready        DDR push (fill mode)
//   o_ddr_r*, i_ddr_rready        DDR pop with lane mask (flush mode)
//   i_drain                       emit a padded partial word in flush mode
//   o_level, o_full, o_empty      occupancy in narrow units
//   o_err_sticky                  bit0 overflow attempt, bit1 underflow attempt
module l2_width_conv_buffer #(
  parameter int NW     = 16,
  parameter int RATIO  = 8,
  parameter int WDEPTH = 512,
  localparam int WW    = NW * RATIO,
  localparam int CAP   = WDEPTH * RATIO,
  localparam int LW    = $clog2(CAP) + 1
) (
  input  logic             clk_166M66,
  input  logic             mcu_sys_rst_n,
  input  logic             i_clear,
  input  logic             i_mode,
  input  logic             i_mode_load,
  output logic             o_mode,
  output logic             o_mode_err,
  input  logic             i_l1_wvalid,
  output logic             o_l1_wready,
  input  logic [NW-1:0]    i_l1_wdata,
  output logic             o_l1_rvalid,
  input  logic             i_l1_rready,
  output logic [NW-1:0]    o_l1_rdata,
  input  logic             i_ddr_wvalid,
  output logic             o_ddr_wready,
  input  logic [WW-1:0]    i_ddr_wdata,
  output logic             o_ddr_rvalid,
  input  logic             i_ddr_rready,
  output logic [WW-1:0]    o_ddr_rdata,
  output logic [RATIO-1:0] o_ddr_rmask,
  input  logic             i_drain,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_err_sticky
);

  localparam int PW = $clog2(CAP);
  localparam int LB = $clog2(RATIO);
  localparam int RW = PW - LB;

  logic [NW-1:0] bank [RATIO][WDEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [LB:0]   pend;      // units pushed at the previous edge, not yet readable
  logic [LB:0]   out_cnt;   // valid lanes held in the DDR output stage
  logic          drain_pending;

  logic [RW-1:0] wrow, rrow;
  logic [LB-1:0] wlane, rlane;
  logic [PW-1:0] rptr_round;

  logic          ddr_push, l1_push, l1_pop, ddr_pop, part_pop;
  logic          fill_load, ddr_full_load, ddr_part_load, mode_accept;
  logic          ovf, unf;
  logic [LW-1:0] push_units, pop_units, level_next, staged, avail;
  logic [LB:0]   ld_cnt;
  logic [WW-1:0] rd_wide;
  logic [RATIO-1:0] rd_mask;

  assign wrow  = wptr[PW-1:LB];
  assign wlane = wptr[LB-1:0];
  assign rrow  = rptr[PW-1:LB];
  assign rlane = rptr[LB-1:0];
  // Flush-mode pointers stay wide-aligned, so the next boundary is one row on.
  assign rptr_round = {rrow + RW'(1), {LB{1'b0}}};

  assign o_full  = (o_level == LW'(CAP));
  assign o_empty = (o_level == '0);

  always_comb begin
    o_ddr_wready = !o_mode && ((LW'(CAP) - o_level) >= LW'(RATIO)) && !i_clear;
    o_l1_wready  = o_mode && !o_full && !drain_pending;

    ddr_push = !o_mode && i_ddr_wvalid && o_ddr_wready;
    l1_push  = o_mode && i_l1_wvalid && o_l1_wready;
    l1_pop   = o_l1_rvalid && i_l1_rready;
    ddr_pop  = o_ddr_rvalid && i_ddr_rready;
    part_pop = ddr_pop && (out_cnt != (LB+1)'(RATIO));

    push_units = ddr_push ? LW'(RATIO) : (l1_push ? LW'(1) : '0);
    pop_units  = l1_pop ? LW'(1) : (ddr_pop ? LW'(out_cnt) : '0);
    level_next = o_level + push_units - pop_units;

    // Entries neither in an output stage nor written at the last edge; the
    // one-edge hold on fresh writes gives the two-edge fall-through latency.
    staged = o_l1_rvalid ? LW'(1) : (o_ddr_rvalid ? LW'(out_cnt) : '0);
    avail  = o_level - staged - LW'(pend);

    fill_load     = !o_mode && (avail != '0) && (!o_l1_rvalid || l1_pop);
    ddr_full_load = o_mode && (avail >= LW'(RATIO)) && (!o_ddr_rvalid || ddr_pop);
    // Padded word only once every full word has left and nothing is in flight.
    ddr_part_load = o_mode && drain_pending && !o_ddr_rvalid && (pend == '0) &&
                    (o_level != '0) && (o_level < LW'(RATIO));

    ld_cnt = (avail >= LW'(RATIO)) ? (LB+1)'(RATIO) : o_level[LB:0];
    for (int k = 0; k < RATIO; k++) begin
      rd_mask[k] = ((LB+1)'(k) < ld_cnt);
      rd_wide[k*NW +: NW] = rd_mask[k] ? bank[k][rrow] : '0;
    end

    mode_accept = i_mode_load && o_empty && !drain_pending;

    ovf = ((i_l1_wvalid && !o_l1_wready) || (i_ddr_wvalid && !o_ddr_wready)) && o_full;
    unf = ((i_l1_rready && !o_l1_rvalid) ||
           (o_mode && i_ddr_rready && !o_ddr_rvalid)) && o_empty;
  end

  always_ff @(posedge clk_166M66) begin
    for (int k = 0; k < RATIO; k++) begin
      if (ddr_push)
        bank[k][wrow] <= i_ddr_wdata[k*NW +: NW];
      else if (l1_push && (wlane == LB'(k)))
        bank[k][wrow] <= i_l1_wdata;
    end
  end

  always_ff @(posedge clk_166M66) begin
    if (!mcu_sys_rst_n || i_clear) begin
      wptr          <= '0;
      rptr          <= '0;
      pend          <= '0;
      out_cnt       <= '0;
      drain_pending <= 1'b0;
      o_level       <= '0;
      o_err_sticky  <= '0;
      o_mode_err    <= 1'b0;
      o_l1_rvalid   <= 1'b0;
      o_l1_rdata    <= '0;
      o_ddr_rvalid  <= 1'b0;
      o_ddr_rdata   <= '0;
      o_ddr_rmask   <= '0;
      if (!mcu_sys_rst_n)
        o_mode <= 1'b0;
    end else begin
      o_mode_err   <= 1'b0;
      o_err_sticky <= o_err_sticky | {unf, ovf};
      if (mode_accept) begin
        // A push coinciding with an accepted load is dropped with the realignment.
        o_mode  <= i_mode;
        wptr    <= '0;
        rptr    <= '0;
        pend    <= '0;
        o_level <= '0;
      end else begin
        if (i_mode_load)
          o_mode_err <= 1'b1;
        o_level <= level_next;
        pend    <= push_units[LB:0];
        drain_pending <= (drain_pending || (o_mode && i_drain && (o_level != '0))) &&
                         (level_next != '0);

        if (part_pop)
          wptr <= rptr_round;
        else if (ddr_push)
          wptr <= wptr + PW'(RATIO);
        else if (l1_push)
          wptr <= wptr + PW'(1);

        if (part_pop)
          rptr <= rptr_round;
        else if (fill_load)
          rptr <= rptr + PW'(1);
        else if (ddr_full_load)
          rptr <= rptr + PW'(RATIO);

        if (fill_load) begin
          o_l1_rvalid <= 1'b1;
          o_l1_rdata  <= bank[rlane][rrow];
        end else if (l1_pop) begin
          o_l1_rvalid <= 1'b0;
        end

        if (ddr_full_load || ddr_part_load) begin
          o_ddr_rvalid <= 1'b1;
          o_ddr_rdata  <= rd_wide;
          o_ddr_rmask  <= rd_mask;
          out_cnt      <= ld_cnt;
        end else if (ddr_pop) begin
          o_ddr_rvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_width_conv_buffer.sv
// tb/tb_l2_width_conv_buffer.sv - directed self-checking bench for l2_width_conv_buffer
module tb_l2_width_conv_buffer;

  logic         clk_166M66 = 1'b0;
  logic         mcu_sys_rst_n;
  logic         i_clear, i_mode, i_mode_load;
  logic         o_mode, o_mode_err;
  logic         i_l1_wvalid, o_l1_wready;
  logic [15:0]  i_l1_wdata;
  logic         o_l1_rvalid, i_l1_rready;
  logic [15:0]  o_l1_rdata;
  logic         i_ddr_wvalid, o_ddr_wready;
  logic [127:0] i_ddr_wdata;
  logic         o_ddr_rvalid, i_ddr_rready;
  logic [127:0] o_ddr_rdata;
  logic [7:0]   o_ddr_rmask;
  logic         i_drain;
  logic [12:0]  o_level;
  logic         o_full, o_empty;
  logic [1:0]   o_err_sticky;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_166M66 = ~clk_166M66;

  l2_width_conv_buffer dut (
    .clk_166M66(clk_166M66), .mcu_sys_rst_n(mcu_sys_rst_n), .i_clear(i_clear),
    .i_mode(i_mode), .i_mode_load(i_mode_load), .o_mode(o_mode), .o_mode_err(o_mode_err),
    .i_l1_wvalid(i_l1_wvalid), .o_l1_wready(o_l1_wready), .i_l1_wdata(i_l1_wdata),
    .o_l1_rvalid(o_l1_rvalid), .i_l1_rready(i_l1_rready), .o_l1_rdata(o_l1_rdata),
    .i_ddr_wvalid(i_ddr_wvalid), .o_ddr_wready(o_ddr_wready), .i_ddr_wdata(i_ddr_wdata),
    .o_ddr_rvalid(o_ddr_rvalid), .i_ddr_rready(i_ddr_rready), .o_ddr_rdata(o_ddr_rdata),
    .o_ddr_rmask(o_ddr_rmask), .i_drain(i_drain), .o_level(o_level), .o_full(o_full),
    .o_empty(o_empty), .o_err_sticky(o_err_sticky)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_166M66);
  endtask

  initial begin
    mcu_sys_rst_n = 1'b0; i_clear = 1'b0; i_mode = 1'b0; i_mode_load = 1'b0;
    i_l1_wvalid = 1'b0; i_l1_wdata = '0; i_l1_rready = 1'b0;
    i_ddr_wvalid = 1'b0; i_ddr_wdata = '0; i_ddr_rready = 1'b0; i_drain = 1'b0;

    // Reset
    tick; tick;
    chk("rst_level", o_level, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_ddr_wready", o_ddr_wready, 1);
    chk("rst_l1_wready", o_l1_wready, 0);
    chk("rst_l1_rvalid", o_l1_rvalid, 0);
    chk("rst_err", o_err_sticky, 0);
    mcu_sys_rst_n = 1'b1;
    tick;

    // Fill: one wide word out as eight narrow words
    i_ddr_wdata = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    i_ddr_wvalid = 1'b1;
    tick;                               // edge N
    i_ddr_wvalid = 1'b0;
    chk("fill_level_push", o_level, 8);
    chk("fill_rvalid_n0", o_l1_rvalid, 0);
    i_l1_rready = 1'b1;
    tick;                               // edge N+1
    chk("fill_rvalid_n1", o_l1_rvalid, 0);
    tick;                               // edge N+2
    for (int k = 0; k < 8; k++) begin
      chk("fill_rvalid", o_l1_rvalid, 1);
      chk("fill_rdata", o_l1_rdata, k);
      chk("fill_level", o_level, 8 - k);
      tick;
    end
    i_l1_rready = 1'b0;
    chk("fill_level_end", o_level, 0);
    chk("fill_empty_end", o_empty, 1);
    chk("fill_rvalid_end", o_l1_rvalid, 0);
    chk("fill_err_none", o_err_sticky, 0);

    // Fill to capacity
    i_ddr_wvalid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      for (int k = 0; k < 8; k++)
        i_ddr_wdata[k*16 +: 16] = 16'(32'h1000 + i*8 + k);
      tick;
    end
    i_ddr_wvalid = 1'b0;
    chk("cap_level", o_level, 4096);
    chk("cap_full", o_full, 1);
    chk("cap_wready", o_ddr_wready, 0);
    chk("cap_err_clean", o_err_sticky, 0);
    i_ddr_wvalid = 1'b1;
    tick;
    i_ddr_wvalid = 1'b0;
    chk("ovf_err", o_err_sticky, 2'b01);
    chk("ovf_level", o_level, 4096);
    chk("cap_rvalid", o_l1_rvalid, 1);
    chk("cap_rdata0", o_l1_rdata, 16'h1000);
    i_l1_rready = 1'b1;
    tick;
    i_l1_rready = 1'b0;
    chk("pop1_level", o_level, 4095);
    chk("pop1_wready", o_ddr_wready, 0);
    chk("pop1_rdata", o_l1_rdata, 16'h1001);
    i_l1_rready = 1'b1;
    repeat (7) tick;
    i_l1_rready = 1'b0;
    chk("pop8_level", o_level, 4088);
    chk("pop8_wready", o_ddr_wready, 1);

    // Clear keeps fill mode
    i_clear = 1'b1;
    tick;
    i_clear = 1'b0;
    chk("clr_level", o_level, 0);
    chk("clr_empty", o_empty, 1);
    chk("clr_mode", o_mode, 0);
    chk("clr_err", o_err_sticky, 0);
    chk("clr_rvalid", o_l1_rvalid, 0);

    // Switch to flush
    i_mode = 1'b1; i_mode_load = 1'b1;
    tick;
    i_mode_load = 1'b0;
    chk("ml_mode", o_mode, 1);
    chk("ml_err", o_mode_err, 0);
    chk("ml_l1_wready", o_l1_wready, 1);
    chk("ml_ddr_wready", o_ddr_wready, 0);

    // Three narrow pushes then drain
    i_l1_wvalid = 1'b1;
    i_l1_wdata = 16'hAAAA; tick;
    i_l1_wdata = 16'hBBBB; tick;
    i_l1_wdata = 16'hCCCC; tick;
    i_l1_wvalid = 1'b0;
    i_drain = 1'b1;
    tick;
    i_drain = 1'b0;
    chk("drn_l1_wready", o_l1_wready, 0);
    for (int n = 0; n < 8 && !o_ddr_rvalid; n++) tick;
    chk("drn_rvalid", o_ddr_rvalid, 1);
    chk("drn_mask", o_ddr_rmask, 8'h07);
    chk("drn_rdata", o_ddr_rdata, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
    chk("drn_level", o_level, 3);
    i_ddr_rready = 1'b1;
    tick;
    i_ddr_rready = 1'b0;
    chk("drn_pop_level", o_level, 0);
    chk("drn_pop_wready", o_l1_wready, 1);
    chk("drn_pop_rvalid", o_ddr_rvalid, 0);

    // Eight pushes give a full word
    i_l1_wvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_l1_wdata = 16'(32'h0100 + k);
      tick;
    end
    i_l1_wvalid = 1'b0;
    for (int n = 0; n < 8 && !o_ddr_rvalid; n++) tick;
    chk("fw_rvalid", o_ddr_rvalid, 1);
    chk("fw_mask", o_ddr_rmask, 8'hFF);
    chk("fw_rdata", o_ddr_rdata, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("fw_level", o_level, 8);

    // Simultaneous L1 push and DDR pop
    i_l1_wvalid = 1'b1; i_l1_wdata = 16'h0200; i_ddr_rready = 1'b1;
    tick;
    i_ddr_rready = 1'b0;
    chk("sim_level", o_level, 1);
    chk("sim_rvalid", o_ddr_rvalid, 0);
    i_l1_wdata = 16'h0201; tick;
    i_l1_wdata = 16'h0202; tick;
    i_l1_wvalid = 1'b0;
    chk("l3_level", o_level, 3);

    // Rejected mode load
    i_mode = 1'b0; i_mode_load = 1'b1;
    tick;
    i_mode_load = 1'b0;
    chk("rej_err_pulse", o_mode_err, 1);
    chk("rej_mode", o_mode, 1);
    tick;
    chk("rej_err_drop", o_mode_err, 0);

    // Clear mid-stream keeps flush mode
    i_clear = 1'b1;
    tick;
    i_clear = 1'b0;
    chk("clr2_level", o_level, 0);
    chk("clr2_empty", o_empty, 1);
    chk("clr2_mode", o_mode, 1);

    // Underflow attempt on DDR side
    i_ddr_rready = 1'b1;
    tick;
    i_ddr_rready = 1'b0;
    chk("unf_err", o_err_sticky, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
